wb_queue: RTL and testbench

//   Writeback buffer between the execute/load units and the 32x32 register

---
 rtl/wb_queue.sv | 131 +++++++++++++
 tb/tb_wb_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue : writeback buffer in front of the 32x32 register file.
//
// Results from the execute/load units are accepted over a valid/ready
// handshake, queued in order, and drained one per cycle into the register
// file write port. Decode can probe two read addresses against the queued
// entries to learn whether a write is still pending (hit) and, if so, which
// value it will eventually see (fwd = data of the youngest matching entry).
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      asynchronous, active-low reset
//   in_valid   producer has a result
//   in_ready   queue can accept (not full)
//   in_addr    destination register of the result
//   in_data    result value
//   rf_ready   register file takes a write this cycle
//   we         register file write enable (queue not empty)
//   wa, wd     head entry address / data (0 when empty)
//   ra1, ra2   decode read addresses
//   hit1, hit2 a queued entry targets ra1 / ra2 (never for register 0)
//   fwd1, fwd2 data of the youngest matching entry, 0 when no hit
//   count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_queue #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_ready,
  output logic                     we,
  output logic [AW-1:0]            wa,
  output logic [DW-1:0]            wd,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DW-1:0]            fwd1,
  output logic [DW-1:0]            fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic accept;
  logic store;
  logic deq;

  // Ready depends only on the registered count: a slot freed by this cycle's
  // dequeue is not reusable until the next cycle.
  assign in_ready = (count != CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  // Writes to register 0 complete the handshake but are discarded.
  assign store    = accept & (in_addr != '0);
  assign deq      = we & rf_ready;

  assign we = (count != '0);
  assign wa = we ? addr_q[rd_ptr] : '0;
  assign wd = we ? data_q[rd_ptr] : '0;

  // Control state: pointers, occupancy and per-entry valid bits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      // store never targets the head slot while it is being dequeued: a
      // non-full, non-empty queue always has wr_ptr != rd_ptr.
      if (store) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (deq) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      count <= count + CW'(store) - CW'(deq);
    end
  end

  // NOTE: the entry storage has no reset; every read of it is qualified by
  // count or a valid bit, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[wr_ptr] <= in_addr;
      data_q[wr_ptr] <= in_data;
    end
  end

  // Forwarding: walk entries oldest to youngest so the last match wins.
  // The head entry still counts while it is being written this cycle.
  logic [PW-1:0] idx;
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the loop can leave a value held (no latch).
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    idx  = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (vld[idx] && (ra1 != '0) && (addr_q[idx] == ra1)) begin
        hit1 = 1'b1;
        fwd1 = data_q[idx];
      end
      if (vld[idx] && (ra2 != '0) && (addr_q[idx] == ra2)) begin
        hit2 = 1'b1;
        fwd2 = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue : self-checking bench for wb_queue.
// A queue of (addr, data) pairs models the buffer; every cycle all outputs
// are compared against it, plus directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rf_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra1, ra2;
  logic          hit1, hit2;
  logic [DW-1:0] fwd1, fwd2;
  logic [CW-1:0] count;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_ready(rf_ready), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model queue.
  task automatic check_model();
    logic          eh1, eh2;
    logic [DW-1:0] ef1, ef2;
    eh1 = 1'b0; eh2 = 1'b0; ef1 = '0; ef2 = '0;
    foreach (mq[i]) begin
      if (ra1 != 0 && mq[i].a == ra1) begin eh1 = 1'b1; ef1 = mq[i].d; end
      if (ra2 != 0 && mq[i].a == ra2) begin eh2 = 1'b1; ef2 = mq[i].d; end
    end
    check("we",       DW'(we),       DW'(mq.size() != 0));
    check("wa",       DW'(wa),       (mq.size() != 0) ? DW'(mq[0].a) : '0);
    check("wd",       wd,            (mq.size() != 0) ? mq[0].d : '0);
    check("count",    DW'(count),    DW'(mq.size()));
    check("in_ready", DW'(in_ready), DW'(mq.size() < DEPTH));
    check("hit1",     DW'(hit1),     DW'(eh1));
    check("fwd1",     fwd1,          ef1);
    check("hit2",     DW'(hit2),     DW'(eh2));
    check("fwd2",     fwd2,          ef2);
  endtask

  // One clock: check at negedge, advance the model at posedge, settle #1.
  task automatic cycle();
    bit acc, dq;
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (reset) begin
      acc = in_valid && (mq.size() < DEPTH);
      dq  = (mq.size() != 0) && rf_ready;
      if (dq) void'(mq.pop_front());
      if (acc && in_addr != 0) mq.push_back('{a: in_addr, d: in_data});
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_addr = '0; in_data = '0; rf_ready = 1'b0; ra1 = '0; ra2 = '0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic rand_in(input int rf_bias);
    in_valid = 1'($urandom_range(0, 1));
    in_addr  = AW'($urandom_range(0, 7));
    in_data  = $urandom;
    rf_ready = ($urandom_range(0, 99) < rf_bias);
    ra1      = AW'($urandom_range(0, 7));
    ra2      = AW'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;

    // 1: reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      rand_in(50);
      @(negedge clk);
      check("rst_we",    DW'(we),       '0);
      check("rst_count", DW'(count),    '0);
      check("rst_ready", DW'(in_ready), 32'd1);
      check("rst_hit1",  DW'(hit1),     '0);
      check("rst_hit2",  DW'(hit2),     '0);
      check("rst_wa",    DW'(wa),       '0);
      check("rst_fwd1",  fwd1,          '0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    idle();

    // 2: single entry, held then drained
    push(5'd3, 32'hAAAA);
    check("t2_we",    DW'(we),    32'd1);
    check("t2_wa",    DW'(wa),    32'd3);
    check("t2_wd",    wd,         32'hAAAA);
    check("t2_count", DW'(count), 32'd1);
    rf_ready = 1'b1;
    cycle();
    check("t2_drain_we",    DW'(we),    '0);
    check("t2_drain_count", DW'(count), '0);
    rf_ready = 1'b0;

    // 3: fill, overflow attempt dropped, drain in order
    for (int k = 1; k <= DEPTH; k++) push(AW'(k), 32'h100 + k);
    check("t3_count", DW'(count),    32'd4);
    check("t3_ready", DW'(in_ready), '0);
    push(5'd9, 32'hDEAD);
    check("t3_drop_count", DW'(count), 32'd4);
    rf_ready = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      check("t3_wa_seq", DW'(wa), DW'(k));
      cycle();
    end
    check("t3_empty_we", DW'(we), '0);
    rf_ready = 1'b0;

    // 4: youngest-match forwarding, register 0 never hits
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    ra1 = 5'd7; ra2 = 5'd0;
    #1;
    check("t4_hit1", DW'(hit1), 32'd1);
    check("t4_fwd1", fwd1,      32'h22);
    check("t4_hit2", DW'(hit2), '0);
    check("t4_fwd2", fwd2,      '0);
    cycle();

    // 5: full queue, valid and rf_ready at the same edge
    push(5'd8, 32'h33);
    push(5'd9, 32'h44);
    check("t5_full", DW'(in_ready), '0);
    in_valid = 1'b1; in_addr = 5'd10; in_data = 32'h55; rf_ready = 1'b1;
    cycle();
    idle();
    check("t5_count", DW'(count),    32'd3);
    check("t5_ready", DW'(in_ready), 32'd1);
    check("t5_head",  DW'(wa),       32'd7);
    cycle();

    // 6: addr 0 accepted but not stored; async reset mid-drain
    do_reset();
    idle();
    push(5'd4, 32'h66);
    push(5'd0, 32'h77);
    check("t6_zero_count", DW'(count), 32'd1);
    push(5'd5, 32'h88);
    check("t6_count2", DW'(count), 32'd2);
    rf_ready = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    mq.delete();
    #1;
    check("t6_rst_count", DW'(count), '0);
    check("t6_rst_we",    DW'(we),    '0);
    check("t6_rst_wd",    wd,         '0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle();

    // Random traffic in phases of differing drain pressure
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 400; k++) begin
        rand_in((p == 0) ? 20 : (p == 1) ? 80 : 50);
        cycle();
      end
    end
    idle();
    rf_ready = 1'b1;
    repeat (DEPTH + 1) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
